conv33_window_gen: RTL

- Producer side of the 3x3 conv window interface: takes a raster-scan pixel stream and emits 3x3 sliding windows (valid convolution, no padding, stride 1).
- Drives the `input_valid` / `input_ready` handshake and the nine window operands of the conv33 input stage.
- Holds two line buffers, a 3x3 shift window, row/col counters and a small fill FSM.
- Sits between the feature-map source (DMA/previous layer) and the conv33 input stage.

---
 rtl/conv33_pkg.sv | 22 ++
 rtl/conv33_window_gen_if.sv | 30 +++
 rtl/conv33_line_buffer.sv | 26 ++
 rtl/conv33_window_gen.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/conv33_pkg.sv
// Shared types, default geometry and width helpers for the conv33 window generator.
package conv33_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int IMG_W_DEF      = 28;
  localparam int IMG_H_DEF      = 28;

  localparam int COL_W         = $clog2(IMG_W_DEF);
  localparam int ROW_W         = $clog2(IMG_H_DEF);
  localparam int WIN_PER_FRAME = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);

  // Counter width for a modulo-n counter; geometry is always >= 3 so this never collapses to 0.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv33_window_gen_if.sv
// Pixel-in / window-out handshake bundle between the generator, its source and the conv33 stage.
interface conv33_window_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  pix_valid;
  logic [DATA_WIDTH-1:0] pix_data;
  logic                  pix_ready;

  logic                  win_valid;
  logic                  win_ready;
  logic [DATA_WIDTH-1:0] win_0_0, win_0_1, win_0_2;
  logic [DATA_WIDTH-1:0] win_1_0, win_1_1, win_1_2;
  logic [DATA_WIDTH-1:0] win_2_0, win_2_1, win_2_2;

  modport master (
    input  pix_valid, pix_data, win_ready,
    output pix_ready, win_valid,
    output win_0_0, win_0_1, win_0_2,
    output win_1_0, win_1_1, win_1_2,
    output win_2_0, win_2_1, win_2_2
  );

  modport slave (
    output pix_valid, pix_data, win_ready,
    input  pix_ready, win_valid,
    input  win_0_0, win_0_1, win_0_2,
    input  win_1_0, win_1_1, win_1_2,
    input  win_2_0, win_2_1, win_2_2
  );
endinterface

// File: rtl/conv33_line_buffer.sv
// One image row of storage; the read port returns the pre-edge contents so a
// same-address write in the same cycle behaves as read-before-write.
module conv33_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 28,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // NOTE: storage has no reset; rows are always rewritten before they are read into an emitted window.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/conv33_window_gen.sv
// Raster-scan to 3x3 sliding-window generator (valid conv, stride 1).
// Optional CONV33_FRAME_DONE_EN adds a frame_done pulse on the last window handshake.
module conv33_window_gen
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF
) (
  input  logic                clk,
  input  logic                rst,
  conv33_window_gen_if.master bus,
  output logic                busy
`ifdef CONV33_FRAME_DONE_EN
  ,
  output logic                frame_done
`endif
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  state_e                r_state;
  logic                  r_busy;
  logic                  r_win_valid;
  logic [DATA_WIDTH-1:0] r_win [3][3];

  logic                  w_pix_ready;
  logic                  w_accept;
  logic                  w_col_last;
  logic                  w_frame_last;
  logic                  w_emit;
  logic [DATA_WIDTH-1:0] w_lb0_rd;
  logic [DATA_WIDTH-1:0] w_lb1_rd;

  // Held low in reset; otherwise any stalled window blocks the source (no skid buffer).
  assign w_pix_ready  = rst & (~r_win_valid | bus.win_ready);
  assign w_accept     = bus.pix_valid & w_pix_ready;
  assign w_col_last   = (r_col == COL_LAST);
  assign w_frame_last = w_col_last & (r_row == ROW_LAST);
  assign w_emit       = (r_state == STREAM) & (r_col >= COL_TWO);

  // lb0 holds row-2, lb1 holds row-1; each accept ages lb1's column into lb0.
  conv33_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_W),
    .AW         (CW)
  ) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (w_lb1_rd),
    .o_rdata (w_lb0_rd)
  );

  conv33_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_W),
    .AW         (CW)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col),
    .i_wdata (bus.pix_data),
    .o_rdata (w_lb1_rd)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_state <= FILL;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_busy <= ~w_frame_last;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
      case (r_state)
        FILL:    if (w_col_last && (r_row == ROW_ONE)) r_state <= STREAM;
        STREAM:  if (w_frame_last) r_state <= FILL;
        default: r_state <= FILL;
      endcase
    end
  end

  // Window shifts only on accept, so a stalled window holds its contents; columns are not flushed at wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= r_win[i][1];
        r_win[i][1] <= r_win[i][2];
      end
      r_win[0][2] <= w_lb0_rd;
      r_win[1][2] <= w_lb1_rd;
      r_win[2][2] <= bus.pix_data;
      r_win_valid <= w_emit;
    end else if (bus.win_ready) begin
      r_win_valid <= 1'b0;
    end
  end

`ifdef CONV33_FRAME_DONE_EN
  logic r_win_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_last <= 1'b0;
    end else if (w_accept) begin
      r_win_last <= w_frame_last;
    end
  end

  assign frame_done = r_win_valid & bus.win_ready & r_win_last;
`endif

  assign bus.pix_ready = w_pix_ready;
  assign bus.win_valid = r_win_valid;
  assign bus.win_0_0   = r_win[0][0];
  assign bus.win_0_1   = r_win[0][1];
  assign bus.win_0_2   = r_win[0][2];
  assign bus.win_1_0   = r_win[1][0];
  assign bus.win_1_1   = r_win[1][1];
  assign bus.win_1_2   = r_win[1][2];
  assign bus.win_2_0   = r_win[2][0];
  assign bus.win_2_1   = r_win[2][1];
  assign bus.win_2_2   = r_win[2][2];
  assign busy          = r_busy;

endmodule
